// File: rtl/contact_ctrl_pkg.sv
// contact_ctrl_pkg: shared definitions for the contact run controller.
//   - command opcodes carried on cmd_op_i
//   - controller state encoding
//   - counter widths used by the top and the watchdog
package contact_ctrl_pkg;

    localparam int SEQ_DONE_W = 16;  // seq_done_o / burst target width
    localparam int PULSE_W    = 32;  // pulse_cnt_o width
    localparam int CORE_CNT_W = 32;  // core_seq_cnt_i width
    localparam int WDOG_W     = 32;  // watchdog counter width

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_RUN   = 2'd1,
        OP_BURST = 2'd2,
        OP_STOP  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    // Core is released from reset only while actually running or draining.
    function automatic logic core_live(state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

    function automatic logic is_busy(state_e s);
        return (s == ST_ARM) || (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/contact_ctrl_wdog.sv
// contact_ctrl_wdog: idle watchdog for the contact run controller.
//   clk_i      in   system clock
//   rst_ni     in   asynchronous reset, active-low
//   en_i       in   count enable; counter is held at 0 while low
//   clr_i      in   activity seen this cycle; restarts the count
//   expired_o  out  counter has reached LIMIT (stays until en_i/clr_i)
module contact_ctrl_wdog
    import contact_ctrl_pkg::*;
#(
    parameter logic [WDOG_W-1:0] LIMIT = 32'h0400_0000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            // saturate at LIMIT so expiry stays asserted
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/contact_ctrl.sv
// contact_ctrl: run controller for the prime-pulse core.
// Accepts RUN / BURST / STOP commands over valid/ready, sequences the core
// reset (IDLE -> ARM -> RUN -> DRAIN) and counts sequences and pulses.
// Optional idle watchdog: define CONTACT_CTRL_WDOG_EN to build it.
//   clk_i / rst_ni         clock, asynchronous active-low reset
//   cmd_valid_i/ready_o    command handshake; cmd_op_i opcode, cmd_arg_i burst count
//   core_rst_o             core reset, level CORE_RST_POL when asserted
//   core_prime_seq_i       core pulse output
//   core_seq_cnt_i         core completed-sequence count
//   busy_o / done_o        in ARM/RUN/DRAIN / 1-cycle completion pulse
//   fault_o                watchdog tripped (0 when watchdog not built)
//   seq_done_o/pulse_cnt_o per-run sequence and pulse counters
module contact_ctrl
    import contact_ctrl_pkg::*;
#(
    parameter int unsigned       RST_HOLD     = 16,
    parameter logic              CORE_RST_POL = 1'b1,
    parameter logic [WDOG_W-1:0] WDOG_CYCLES  = 32'h0400_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [SEQ_DONE_W-1:0] cmd_arg_i,
    output logic                  core_rst_o,
    input  logic                  core_prime_seq_i,
    input  logic [CORE_CNT_W-1:0] core_seq_cnt_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fault_o,
    output logic [SEQ_DONE_W-1:0] seq_done_o,
    output logic [PULSE_W-1:0]    pulse_cnt_o
);

    localparam int HOLD_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD);

    if (RST_HOLD < 1) begin : g_bad_hold
        $error("contact_ctrl: RST_HOLD must be >= 1");
    end
    if (WDOG_CYCLES == '0) begin : g_bad_wdog
        $error("contact_ctrl: WDOG_CYCLES must be non-zero");
    end

    state_e                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [SEQ_DONE_W-1:0]  seq_done_q, seq_done_d, target_q, target_d;
    logic [PULSE_W-1:0]     pulse_q, pulse_d;
    logic                   burst_q, burst_d;
    logic                   ready_q, busy_q, done_q, done_d, core_rst_q;

    // Core inputs are registered once; edges/changes compare against the
    // previous registered copy.
    logic                   prime_q, prime_prev_q;
    logic [CORE_CNT_W-1:0]  seq_q, seq_prev_q;

    logic                   accept, pulse_edge, seq_chg, wdog_trip;
    logic [SEQ_DONE_W-1:0]  seq_inc;
    op_e                    op;

    assign accept     = cmd_valid_i & ready_q;
    assign op         = op_e'(cmd_op_i);
    assign pulse_edge = prime_q & ~prime_prev_q;
    assign seq_chg    = (seq_q != seq_prev_q);   // wrap FFFF_FFFF->0 is a change too
    assign seq_inc    = seq_done_q + 1'b1;

`ifdef CONTACT_CTRL_WDOG_EN
    logic wdog_exp;
    logic fault_q;

    contact_ctrl_wdog #(.LIMIT(WDOG_CYCLES)) u_wdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (core_live(state_q)),
        .clr_i     (pulse_edge | seq_chg),
        .expired_o (wdog_exp)
    );

    // A cycle with activity is not idle, even if the count just expired.
    assign wdog_trip = wdog_exp & ~(pulse_edge | seq_chg);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fault_q <= 1'b0;
        else         fault_q <= (state_d == ST_FAULT);
    end
    assign fault_o = fault_q;
`else
    assign wdog_trip = 1'b0;
    assign fault_o   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        seq_done_d = seq_done_q;
        pulse_d    = pulse_q;
        target_d   = target_q;
        burst_d    = burst_q;
        done_d     = 1'b0;

        if (core_live(state_q) && pulse_edge) pulse_d = pulse_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (accept && (op == OP_RUN || op == OP_BURST)) begin
                    if (op == OP_BURST && cmd_arg_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_ARM;
                        hold_d     = '0;
                        seq_done_d = '0;
                        pulse_d    = '0;
                        burst_d    = (op == OP_BURST);
                        target_d   = cmd_arg_i;
                    end
                end
            end
            ST_ARM: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_W'(RST_HOLD - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (seq_chg) seq_done_d = seq_inc;
                // burst completion beats a STOP arriving in the same cycle
                if (seq_chg && burst_q && seq_inc == target_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (accept && op == OP_STOP) begin
                    state_d = ST_DRAIN;
                end else if (wdog_trip) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DRAIN: begin
                if (seq_chg) begin
                    seq_done_d = seq_inc;
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                end else if (accept && op == OP_STOP) begin
                    state_d = ST_IDLE;   // abort: no done
                end else if (wdog_trip) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (accept && op == OP_STOP) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            seq_done_q   <= '0;
            pulse_q      <= '0;
            target_q     <= '0;
            burst_q      <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            core_rst_q   <= CORE_RST_POL;
            prime_q      <= 1'b0;
            prime_prev_q <= 1'b0;
            seq_q        <= '0;
            seq_prev_q   <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            seq_done_q   <= seq_done_d;
            pulse_q      <= pulse_d;
            target_q     <= target_d;
            burst_q      <= burst_d;
            ready_q      <= (state_d != ST_ARM);
            busy_q       <= is_busy(state_d);
            done_q       <= done_d;
            core_rst_q   <= core_live(state_d) ? ~CORE_RST_POL : CORE_RST_POL;
            prime_q      <= core_prime_seq_i;
            prime_prev_q <= prime_q;
            seq_q        <= core_seq_cnt_i;
            seq_prev_q   <= seq_q;
        end
    end

    assign cmd_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign core_rst_o  = core_rst_q;
    assign seq_done_o  = seq_done_q;
    assign pulse_cnt_o = pulse_q;

endmodule

// File: tb/tb_contact_ctrl.sv
module tb_contact_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_arg = 16'd0;
    logic        core_rst;
    logic        prime = 1'b0;
    logic [31:0] seq_cnt = 32'd0;
    logic        busy, done, fault;
    logic [15:0] seq_done;
    logic [31:0] pulse_cnt;

    int total = 0;
    int bad   = 0;

    // core model controls
    logic        freeze = 1'b0;
    logic        preload_req = 1'b0;
    logic [31:0] preload_val = 32'd0;
    int          t = 0;

    always #5 clk = ~clk;

    contact_ctrl #(.RST_HOLD(4), .CORE_RST_POL(1'b1), .WDOG_CYCLES(32'd100)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_op_i         (cmd_op),
        .cmd_arg_i        (cmd_arg),
        .core_rst_o       (core_rst),
        .core_prime_seq_i (prime),
        .core_seq_cnt_i   (seq_cnt),
        .busy_o           (busy),
        .done_o           (done),
        .fault_o          (fault),
        .seq_done_o       (seq_done),
        .pulse_cnt_o      (pulse_cnt)
    );

    // Core model: 50-cycle sequences, 3 one-cycle pulses each, count held
    // across core reset so it can be preloaded.
    always @(posedge clk) begin
        if (preload_req) begin
            seq_cnt <= preload_val;
        end else if (core_rst) begin
            t     <= 0;
            prime <= 1'b0;
        end else if (!freeze) begin
            t     <= (t == 49) ? 0 : t + 1;
            prime <= (t == 9 || t == 19 || t == 29);
            if (t == 49) seq_cnt <= seq_cnt + 32'd1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a command from a negedge; returns on the negedge after acceptance.
    task automatic issue(input logic [1:0] op, input logic [15:0] arg);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL issue_ready op=%0d: got %b want 1", op, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 16'd0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(negedge clk); n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL %s_timeout: no done within %0d cycles", name, bound);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(5);
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL rst_core_rst: got %b want 1", core_rst); end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
        total++; if ({busy, done, fault} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {busy, done, fault}); end
        total++; if (seq_done !== 16'd0 || pulse_cnt !== 32'd0) begin
            bad++; $display("FAIL rst_counters: got %0d/%0d want 0/0", seq_done, pulse_cnt); end
        rst_n = 1'b1;
        tick(1);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
        total++; if (core_rst !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_release_idle: core_rst=%b busy=%b want 1/0", core_rst, busy); end
    endtask

    task automatic test_burst();
        issue(2'd2, 16'd3);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (busy !== 1'b1 || core_rst !== 1'b1 || cmd_ready !== 1'b0) begin
                bad++; $display("FAIL burst_arm%0d: busy=%b core_rst=%b ready=%b want 1/1/0", i, busy, core_rst, cmd_ready);
            end
            tick(1);
        end
        total++; if (core_rst !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL burst_run: core_rst=%b ready=%b busy=%b want 0/1/1", core_rst, cmd_ready, busy); end
        wait_done("burst", 300);
        total++; if (seq_done !== 16'd3) begin bad++; $display("FAIL burst_seq_done: got %0d want 3", seq_done); end
        total++; if (pulse_cnt !== 32'd9) begin bad++; $display("FAIL burst_pulse_cnt: got %0d want 9", pulse_cnt); end
        total++; if (core_rst !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL burst_end_state: core_rst=%b busy=%b want 1/0", core_rst, busy); end
        tick(1);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL burst_done_width: got %b want 0", done); end
    endtask

    task automatic test_run_stop();
        issue(2'd1, 16'd0);
        tick(79);   // 75 cycles into RUN, second sequence in progress
        total++; if (seq_done !== 16'd1 || pulse_cnt !== 32'd5) begin
            bad++; $display("FAIL run_mid: seq_done=%0d pulse=%0d want 1/5", seq_done, pulse_cnt); end
        issue(2'd3, 16'd0);
        total++; if (busy !== 1'b1 || core_rst !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL drain_enter: busy=%b core_rst=%b done=%b want 1/0/0", busy, core_rst, done); end
        wait_done("drain", 200);
        total++; if (seq_done !== 16'd2 || pulse_cnt !== 32'd6) begin
            bad++; $display("FAIL drain_counts: seq_done=%0d pulse=%0d want 2/6", seq_done, pulse_cnt); end
        total++; if (busy !== 1'b0 || core_rst !== 1'b1) begin
            bad++; $display("FAIL drain_end: busy=%b core_rst=%b want 0/1", busy, core_rst); end
    endtask

    task automatic test_double_stop();
        int dones = 0;
        issue(2'd1, 16'd0);
        tick(30);
        issue(2'd3, 16'd0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL dstop_drain: busy=%b want 1", busy); end
        issue(2'd3, 16'd0);
        total++; if (busy !== 1'b0 || done !== 1'b0 || core_rst !== 1'b1) begin
            bad++; $display("FAIL dstop_abort: busy=%b done=%b core_rst=%b want 0/0/1", busy, done, core_rst); end
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) dones++;
            tick(1);
        end
        total++; if (dones != 0) begin bad++; $display("FAIL dstop_no_done: got %0d dones want 0", dones); end
        total++; if (seq_done !== 16'd0 || pulse_cnt !== 32'd2) begin
            bad++; $display("FAIL dstop_hold: seq_done=%0d pulse=%0d want 0/2", seq_done, pulse_cnt); end
    endtask

    task automatic test_burst_zero();
        issue(2'd2, 16'd0);
        total++; if (done !== 1'b1 || busy !== 1'b0 || core_rst !== 1'b1) begin
            bad++; $display("FAIL bzero_done: done=%b busy=%b core_rst=%b want 1/0/1", done, busy, core_rst); end
        tick(1);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL bzero_after: done=%b busy=%b want 0/0", done, busy); end
        total++; if (pulse_cnt !== 32'd2) begin bad++; $display("FAIL bzero_hold: pulse=%0d want 2", pulse_cnt); end
    endtask

    task automatic test_stop_on_complete();
        int dones = 0;
        issue(2'd2, 16'd1);
        tick(55);   // STOP lands on the completion edge
        cmd_valid = 1'b1; cmd_op = 2'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'd0;
        total++; if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL soc_done: done=%b busy=%b want 1/0", done, busy); end
        total++; if (seq_done !== 16'd1 || pulse_cnt !== 32'd3) begin
            bad++; $display("FAIL soc_counts: seq_done=%0d pulse=%0d want 1/3", seq_done, pulse_cnt); end
        tick(1);
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) dones++;
            tick(1);
        end
        total++; if (dones != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL soc_single: extra dones=%0d busy=%b want 0/0", dones, busy); end
    endtask

    task automatic test_wrap();
        preload_val = 32'hFFFF_FFFF; preload_req = 1'b1;
        tick(1);
        preload_req = 1'b0;
        tick(3);
        total++; if (seq_done !== 16'd1) begin bad++; $display("FAIL wrap_idle_hold: seq_done=%0d want 1", seq_done); end
        issue(2'd2, 16'd1);
        wait_done("wrap", 200);
        total++; if (seq_done !== 16'd1 || pulse_cnt !== 32'd3) begin
            bad++; $display("FAIL wrap_counts: seq_done=%0d pulse=%0d want 1/3", seq_done, pulse_cnt); end
    endtask

    task automatic test_wdog();
`ifdef CONTACT_CTRL_WDOG_EN
        int n = 0;
        issue(2'd1, 16'd0);
        tick(60);
        freeze = 1'b1;
        while (fault !== 1'b1 && n < 300) begin tick(1); n++; end
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL wdog_trip: fault=%b want 1", fault); end
        total++; if (n < 95 || n > 110) begin bad++; $display("FAIL wdog_latency: got %0d cycles want 95..110", n); end
        total++; if (core_rst !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL wdog_state: core_rst=%b busy=%b ready=%b want 1/0/1", core_rst, busy, cmd_ready); end
        issue(2'd1, 16'd0);   // ignored in FAULT
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL wdog_sticky: fault=%b want 1", fault); end
        issue(2'd3, 16'd0);
        total++; if (fault !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL wdog_clear: fault=%b busy=%b want 0/0", fault, busy); end
        freeze = 1'b0;
`else
        issue(2'd1, 16'd0);
        tick(60);
        freeze = 1'b1;
        tick(200);
        total++; if (fault !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL nowdog: fault=%b busy=%b want 0/1", fault, busy); end
        issue(2'd3, 16'd0);
        issue(2'd3, 16'd0);
        freeze = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nowdog_stop: busy=%b want 0", busy); end
`endif
    endtask

    task automatic test_async_reset();
        issue(2'd1, 16'd0);
        tick(20);
        #2 rst_n = 1'b0;
        #1;
        total++; if (core_rst !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            bad++; $display("FAIL arst_state: core_rst=%b busy=%b ready=%b want 1/0/0", core_rst, busy, cmd_ready); end
        total++; if (seq_done !== 16'd0 || pulse_cnt !== 32'd0) begin
            bad++; $display("FAIL arst_counters: seq_done=%0d pulse=%0d want 0/0", seq_done, pulse_cnt); end
        tick(2);
        rst_n = 1'b1;
        tick(1);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL arst_release: ready=%b want 1", cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_run_stop();
        test_double_stop();
        test_burst_zero();
        test_stop_on_complete();
        test_wrap();
        test_wdog();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
